// File: rtl/usr_cmd_sequencer.sv
// Command front-end for the 4-bit universal shift register: takes one command per
// valid/ready handshake and drives sel/pin/slin/srin, then pulses done. Optional rotate: USR_SEQ_ROTATE_EN.
module usr_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    // Handshake: a command transfers on a rising edge where cmd_valid_i and cmd_ready_o are both high.
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [CNT_W-1:0] cmd_cnt_i,
    input  logic             cmd_fill_i,
`ifdef USR_SEQ_ROTATE_EN
    input  logic             cmd_rot_i,
    input  logic [WIDTH-1:0] usr_q_i,
`endif
    output logic [1:0]       sel_o,
    output logic [WIDTH-1:0] pin_o,
    output logic             slin_o,
    output logic             srin_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               accept;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   data_q;
    logic               fill_q;
    logic [CNT_W-1:0]   rem_q;
`ifdef USR_SEQ_ROTATE_EN
    logic               rot_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Command registers; rem counts the remaining register cycles of the current command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 2'b00;
            data_q <= '0;
            fill_q <= 1'b0;
            rem_q  <= '0;
`ifdef USR_SEQ_ROTATE_EN
            rot_q  <= 1'b0;
`endif
        end else if (accept) begin
            op_q   <= cmd_op_i;
            data_q <= cmd_data_i;
            fill_q <= cmd_fill_i;
            rem_q  <= (cmd_op_i == 2'b11) ? CNT_W'(1) : cmd_cnt_i;
`ifdef USR_SEQ_ROTATE_EN
            rot_q  <= cmd_rot_i;
`endif
        end else if (state_q == RUN) begin
            rem_q  <= rem_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        sel_o       = 2'b00;
        pin_o       = data_q;
        slin_o      = 1'b0;
        srin_o      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    accept = 1'b1;
                    // A zero-count shift/hold is a no-op: skip straight to the done pulse.
                    if (cmd_op_i != 2'b11 && cmd_cnt_i == '0) state_d = DONE;
                    else                                      state_d = RUN;
                end
            end
            RUN: begin
                sel_o  = op_q;
                slin_o = fill_q;
                srin_o = fill_q;
`ifdef USR_SEQ_ROTATE_EN
                if (rot_q) begin
                    slin_o = usr_q_i[0];
                    srin_o = usr_q_i[WIDTH-1];
                end
`endif
                if (rem_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: drives commands into the sequencer feeding a simple USR model
// and checks per-cycle outputs and final register contents. Rotate cases need USR_SEQ_ROTATE_EN.
module tb_usr_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic       cmd_fill;
    logic       cmd_rot;
    logic [1:0] sel;
    logic [3:0] pin;
    logic       slin, srin, busy, done;
    logic [3:0] usr;

    int errors = 0;
    int checks = 0;
    time last_acc = 0;

    usr_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .cmd_cnt_i   (cmd_cnt),
        .cmd_fill_i  (cmd_fill),
`ifdef USR_SEQ_ROTATE_EN
        .cmd_rot_i   (cmd_rot),
        .usr_q_i     (usr),
`endif
        .sel_o       (sel),
        .pin_o       (pin),
        .slin_o      (slin),
        .srin_o      (srin),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register (never reset by the sequencer's rst).
    initial usr = 4'h0;
    always @(posedge clk) begin
        case (sel)
            2'b01:   usr <= {slin, usr[3:1]};
            2'b10:   usr <= {usr[2:0], srin};
            2'b11:   usr <= pin;
            default: usr <= usr;
        endcase
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected register contents after a whole command, from the op's meaning.
    function automatic logic [3:0] exp_usr(logic [3:0] u, logic [1:0] op, logic [3:0] d,
                                           int cnt, logic fill, logic rot);
        logic [3:0] r;
        logic [3:0] ones;
        logic [3:0] m;
        r    = u;
        ones = 4'hF;
        case (op)
            2'b11: r = d;
            2'b01: begin
                if (rot) begin
                    for (int i = 0; i < cnt; i++) r = {r[0], r[3:1]};
                end else begin
                    r = u >> cnt;
                    m = ones >> cnt;
                    if (fill) r = r | ~m;
                end
            end
            2'b10: begin
                if (rot) begin
                    for (int i = 0; i < cnt; i++) r = {r[2:0], r[3]};
                end else begin
                    r = u << cnt;
                    m = ones << cnt;
                    if (fill) r = r | ~m;
                end
            end
            default: r = u;
        endcase
        return r;
    endfunction

    // Issues one command from an IDLE negedge; returns at the following IDLE negedge.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] d, input int cnt,
                           input logic fill, input logic rot, input logic keep,
                           input logic [3:0] exp_final, input int exp_gap, input string tag);
        int  n;
        time acc;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = 3'(cnt);
        cmd_fill  = fill;
        cmd_rot   = rot;
        cmd_valid = 1'b1;
        chk({tag, " ready_idle"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        acc = $time;
        if (exp_gap >= 0) chk({tag, " accept_gap"}, 32'((acc - last_acc) / 10), 32'(exp_gap));
        last_acc = acc;
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        n = (op == 2'b11) ? 1 : cnt;
        for (int i = 0; i < n; i++) begin
            chk({tag, " run_sel"}, 32'(sel), 32'(op));
            chk({tag, " run_busy"}, 32'(busy), 32'd1);
            chk({tag, " run_ready"}, 32'(cmd_ready), 32'd0);
            chk({tag, " run_done"}, 32'(done), 32'd0);
            chk({tag, " run_pin"}, 32'(pin), 32'(d));
            chk({tag, " run_slin"}, 32'(slin), 32'(rot ? usr[0] : fill));
            chk({tag, " run_srin"}, 32'(srin), 32'(rot ? usr[3] : fill));
            @(negedge clk);
        end
        chk({tag, " done_pulse"}, 32'(done), 32'd1);
        chk({tag, " done_sel"}, 32'(sel), 32'd0);
        chk({tag, " done_busy"}, 32'(busy), 32'd1);
        chk({tag, " done_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, " done_serial"}, 32'({slin, srin}), 32'd0);
        chk({tag, " done_pin"}, 32'(pin), 32'(d));
        @(negedge clk);
        chk({tag, " idle_done"}, 32'(done), 32'd0);
        chk({tag, " idle_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk({tag, " idle_sel"}, 32'(sel), 32'd0);
        chk({tag, " usr_final"}, 32'(usr), 32'(exp_final));
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        int         cnt;
        logic       fill;
        logic       rot;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [1:0] r_op;
        logic [3:0] r_data;
        int         r_cnt;
        logic       r_fill, r_rot;
        logic [3:0] e;

        tbl.push_back('{2'b11, 4'hA, 0, 1'b0, 1'b0, 4'hA}); // load A
        tbl.push_back('{2'b01, 4'h0, 2, 1'b1, 1'b0, 4'hE}); // A >> 2, fill 1
        tbl.push_back('{2'b10, 4'h0, 0, 1'b1, 1'b0, 4'hE}); // zero-count no-op
        tbl.push_back('{2'b00, 4'h0, 3, 1'b1, 1'b0, 4'hE}); // hold 3 cycles
        tbl.push_back('{2'b10, 4'h0, 1, 1'b0, 1'b0, 4'hC}); // E << 1, fill 0
        tbl.push_back('{2'b11, 4'h5, 0, 1'b0, 1'b0, 4'h5}); // load 5
        tbl.push_back('{2'b10, 4'h0, 7, 1'b1, 1'b0, 4'hF}); // max count, fill 1
        tbl.push_back('{2'b01, 4'h0, 4, 1'b0, 1'b0, 4'h0}); // shift everything out
        tbl.push_back('{2'b11, 4'h6, 5, 1'b0, 1'b0, 4'h6}); // load ignores count
`ifdef USR_SEQ_ROTATE_EN
        tbl.push_back('{2'b11, 4'h9, 0, 1'b0, 1'b0, 4'h9}); // load 1001
        tbl.push_back('{2'b10, 4'h0, 3, 1'b1, 1'b1, 4'hC}); // rotate left 3
        tbl.push_back('{2'b01, 4'h0, 1, 1'b1, 1'b1, 4'h6}); // rotate right 1
`endif

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'h0;
        cmd_cnt   = 3'd0;
        cmd_fill  = 1'b0;
        cmd_rot   = 1'b0;
        #12;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_pin", 32'(pin), 32'd0);
        chk("reset_serial", 32'({slin, srin}), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // Reset mid-RUN aborts the command without a done pulse.
        cmd_op = 2'b01; cmd_data = 4'h3; cmd_cnt = 3'd5; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_run1_sel", 32'(sel), 32'd1);
        @(negedge clk);
        chk("abort_run2_sel", 32'(sel), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_sel", 32'(sel), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_ready", 32'(cmd_ready), 32'd1);
            chk("abort_idle_sel", 32'(sel), 32'd0);
            @(negedge clk);
        end

        foreach (tbl[i])
            run_cmd(tbl[i].op, tbl[i].data, tbl[i].cnt, tbl[i].fill, tbl[i].rot, 1'b0,
                    tbl[i].exp, -1, $sformatf("vec%0d", i));

        // Valid held across two commands: the second transfers only back in IDLE.
        e = exp_usr(usr, 2'b01, 4'h3, 3, 1'b1, 1'b0);
        run_cmd(2'b01, 4'h3, 3, 1'b1, 1'b0, 1'b1, e, -1, "b2b_first");
        e = exp_usr(usr, 2'b01, 4'h3, 3, 1'b1, 1'b0);
        run_cmd(2'b01, 4'h3, 3, 1'b1, 1'b0, 1'b0, e, 5, "b2b_second");

        for (int k = 0; k < 40; k++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_data = 4'($urandom_range(0, 15));
            r_cnt  = $urandom_range(0, 7);
            r_fill = 1'($urandom_range(0, 1));
            r_rot  = 1'b0;
`ifdef USR_SEQ_ROTATE_EN
            r_rot  = 1'($urandom_range(0, 1));
`endif
            e = exp_usr(usr, r_op, r_data, r_cnt, r_fill, r_rot);
            run_cmd(r_op, r_data, r_cnt, r_fill, r_rot, 1'b0, e, -1, $sformatf("rnd%0d", k));
            repeat ($urandom_range(0, 2)) begin
                chk("rnd_gap_sel", 32'(sel), 32'd0);
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
